// File: rtl/muldiv_unit.sv
// muldiv_unit: HI/LO multiply/divide unit with a fixed-latency multiply and a 32-step restoring divide
module muldiv_unit #(
  parameter int MUL_LAT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        flush,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;
  state_t state, nxt;
  logic [31:0] a_q, b_q, rem, quo, bm, q_fix, r_fix;
  logic [1:0]  op_q;
  logic [4:0]  cnt;
  logic [65:0] prod;
  logic [32:0] shl, diff;
  logic        accept, fin, sgn, a_neg, b_neg;
  assign accept = state == IDLE && start && !flush;
  assign fin    = !flush && ((state == MUL && cnt == 5'd0) || state == FIX);
  assign sgn    = !op_q[0];
  assign a_neg  = sgn && a_q[31];
  assign b_neg  = sgn && b_q[31];
  assign bm     = b_neg ? -b_q : b_q;
  assign prod   = $signed({{34{sgn & a_q[31]}}, a_q}) * $signed({{34{sgn & b_q[31]}}, b_q});
  assign shl    = {rem, quo[31]};
  assign diff   = shl - {1'b0, bm};
  assign q_fix  = (a_neg ^ b_neg) ? -quo : quo;
  assign r_fix  = a_neg ? -rem : rem;
  always_comb begin
    nxt = state;
    if (flush) nxt = IDLE;
    else if (state == IDLE) nxt = start ? (op[1] ? DIV : MUL) : IDLE;
    else if (state == MUL) nxt = cnt == 5'd0 ? IDLE : MUL;
    else if (state == DIV) nxt = cnt == 5'd0 ? FIX : DIV;
    else nxt = IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= nxt;
      busy  <= nxt != IDLE;
      done  <= fin;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      hi   <= '0;
      lo   <= '0;
      a_q  <= '0;
      b_q  <= '0;
      op_q <= '0;
      rem  <= '0;
      quo  <= '0;
      cnt  <= '0;
    end else begin
      if (state == IDLE && hi_we) hi <= wdata;
      if (state == IDLE && lo_we) lo <= wdata;
      if (accept) begin
        a_q  <= a;
        b_q  <= b;
        op_q <= op;
        rem  <= '0;
        quo  <= (op == 2'd2 && a[31]) ? -a : a;
        cnt  <= op[1] ? 5'd31 : 5'(MUL_LAT - 1);
      end
      if (!flush && (state == MUL || state == DIV)) cnt <= cnt - 5'd1;
      if (state == DIV) begin
        rem <= diff[32] ? shl[31:0] : diff[31:0];
        quo <= {quo[30:0], !diff[32]};
      end
      if (fin && state == MUL) begin
        hi <= prod[63:32];
        lo <= prod[31:0];
      end
      if (fin && state == FIX) begin
        hi <= b_q == '0 ? a_q : r_fix;
        lo <= b_q == '0 ? 32'hFFFF_FFFF : q_fix;
      end
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed checks of multiply/divide timing, results, flush, MTHI/MTLO and reset
module tb_muldiv_unit;
  logic        clk = 1'b0, reset = 1'b1, start = 1'b0, flush = 1'b0, hi_we = 1'b0, lo_we = 1'b0;
  logic [1:0]  op = '0;
  logic [31:0] a = '0, b = '0, wdata = '0;
  logic        busy, done;
  logic [31:0] hi, lo;
  int          vecs = 0, miss = 0;
  muldiv_unit #(.MUL_LAT(4)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b), .flush(flush),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic go(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1;
    op = o;
    a = x;
    b = y;
    tick();
    start = 1'b0;
  endtask
  task automatic finish(input string tag, input int n, input logic [31:0] eh, input logic [31:0] el);
    int k = 0;
    logic early = 1'b0;
    while (busy === 1'b1 && k < 40) begin
      early |= done;
      k++;
      tick();
    end
    check({tag, " busy cycles"}, 64'(k), 64'(n));
    check({tag, " done early"}, 64'(early), 64'd0);
    check({tag, " done"}, 64'(done), 64'd1);
    check({tag, " hi"}, 64'(hi), 64'(eh));
    check({tag, " lo"}, 64'(lo), 64'(el));
  endtask
  initial begin
    logic seen;
    tick();
    reset = 1'b0;
    check("reset hi", 64'(hi), 64'd0);
    check("reset lo", 64'(lo), 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    go(2'd0, 32'hFFFF_FFFD, 32'd5);
    check("mult busy rise", 64'(busy), 64'd1);
    finish("mult", 4, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    go(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("b2b accepted", 64'(busy), 64'd1);
    check("b2b done cleared", 64'(done), 64'd0);
    finish("multu", 4, 32'hFFFF_FFFE, 32'h0000_0001);
    tick();
    check("multu done pulse", 64'(done), 64'd0);
    go(2'd2, 32'hFFFF_FFF9, 32'd2);
    finish("div -7/2", 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    tick();
    check("div done pulse", 64'(done), 64'd0);
    go(2'd3, 32'h1234, 32'd0);
    finish("divu /0", 33, 32'h1234, 32'hFFFF_FFFF);
    tick();
    go(2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    finish("div ovf", 33, 32'd0, 32'h8000_0000);
    tick();
    go(2'd2, 32'd7, 32'hFFFF_FFFE);
    finish("div 7/-2", 33, 32'd1, 32'hFFFF_FFFD);
    tick();
    go(2'd3, 32'hFFFF_FFFF, 32'd10);
    finish("divu big", 33, 32'd5, 32'h1999_9999);
    tick();
    lo_we = 1'b1;
    wdata = 32'h1357_9BDF;
    tick();
    lo_we = 1'b0;
    check("mtlo idle", 64'(lo), 64'h1357_9BDF);
    hi_we = 1'b1;
    wdata = 32'hDEAD_BEEF;
    go(2'd1, 32'd3, 32'd4);
    hi_we = 1'b0;
    check("mthi with start", 64'(hi), 64'hDEAD_BEEF);
    finish("multu 3*4", 4, 32'd0, 32'd12);
    tick();
    go(2'd2, 32'd100, 32'd7);
    repeat (4) tick();
    hi_we = 1'b1;
    wdata = 32'hA5A5_A5A5;
    start = 1'b1;
    op = 2'd1;
    tick();
    hi_we = 1'b0;
    start = 1'b0;
    check("busy after ignored start", 64'(busy), 64'd1);
    repeat (4) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush busy", 64'(busy), 64'd0);
    check("flush done", 64'(done), 64'd0);
    seen = 1'b0;
    repeat (40) begin
      seen |= done | busy;
      tick();
    end
    check("flush quiet", 64'(seen), 64'd0);
    check("flush hi", 64'(hi), 64'd0);
    check("flush lo", 64'(lo), 64'd12);
    flush = 1'b1;
    go(2'd1, 32'd9, 32'd9);
    flush = 1'b0;
    check("flush beats start", 64'(busy), 64'd0);
    go(2'd3, 32'd1000, 32'd3);
    repeat (19) tick();
    check("div cycle 20 busy", 64'(busy), 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort hi", 64'(hi), 64'd0);
    check("abort lo", 64'(lo), 64'd0);
    check("abort busy", 64'(busy), 64'd0);
    check("abort done", 64'(done), 64'd0);
    seen = 1'b0;
    repeat (40) begin
      seen |= done;
      tick();
    end
    check("abort no done", 64'(seen), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end
endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL take parameter MUL_LAT, default 4, giving the multiply latency in busy cycles; legal range is 1..8.
REQ-002 The block SHALL have port clk, input, 1 bit, the system clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit, the reset, synchronous and active-high.
REQ-004 The block SHALL have port start, input, 1 bit, the request to begin an operation.
REQ-005 The block SHALL have port op, input, 2 bits, the operation: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU.
REQ-006 The block SHALL have ports a and b, input, 32 bits each: a is the multiplicand/dividend, b is the multiplier/divisor.
REQ-007 The block SHALL have port flush, input, 1 bit, which aborts any operation in flight.
REQ-008 The block SHALL have ports hi_we and lo_we, input, 1 bit each, the MTHI and MTLO write enables.
REQ-009 The block SHALL have port wdata, input, 32 bits, the MTHI/MTLO write data.
REQ-010 The block SHALL have port busy, output, 1 bit, high while an operation is in progress; it is the execute-stage stall source.
REQ-011 The block SHALL have port done, output, 1 bit, a one-cycle pulse when hi and lo hold a new result.
REQ-012 The block SHALL have ports hi and lo, output, 32 bits each, the architectural HI/LO registers.

Function
REQ-013 The block SHALL have states IDLE, MUL, DIV and FIX; start is accepted only in IDLE, with flush=0, and only at a rising edge.
REQ-014 Accepting start SHALL latch a, b and op; the next state is MUL for op 0/1 and DIV for op 2/3.
REQ-015 For an acceptance at cycle T, busy SHALL be 1 for cycles T+1..T+N and 0 otherwise, with N=MUL_LAT for a multiply and N=33 for a divide.
REQ-016 hi and lo SHALL update at the edge ending cycle T+N; done SHALL be 1 in cycle T+N+1 only, and the state is IDLE in that cycle.
REQ-017 A multiply SHALL produce the full 64-bit product {hi,lo}: two's-complement for MULT, unsigned for MULTU.
REQ-018 A divide SHALL run 32 restoring-divide iterations on magnitudes in the DIV state, then one FIX cycle for sign correction.
REQ-019 Divide results SHALL be lo = quotient truncated toward zero and hi = remainder; for DIV, the remainder sign equals the sign of a.
REQ-020 DIV of 0x80000000 by 0xFFFFFFFF SHALL give lo=0x80000000 and hi=0 with no exception.
REQ-021 Divide by b=0 SHALL give hi=a and lo=0xFFFFFFFF, with the same 33-cycle timing.
REQ-022 start while busy=1 SHALL be ignored; no queuing.
REQ-023 start in the done cycle SHALL be accepted, so back-to-back operations are legal.
REQ-024 flush=1 SHALL force the state to IDLE at the next edge: busy=0 next cycle, no done, hi/lo unchanged.
REQ-025 If flush and start are both high in IDLE, flush SHALL win and start is not accepted.
REQ-026 hi_we/lo_we SHALL write wdata only when state is IDLE; they are ignored while busy.
REQ-027 If a write enable coincides with an accepted start, the write SHALL take effect now and the result SHALL overwrite it later.
REQ-028 Outputs busy and done SHALL be registered, and hi and lo SHALL be driven directly from registers.

Reset
REQ-029 With reset=1, at the next edge the state SHALL become IDLE and hi=lo=0, busy=0, done=0, with internal counters cleared.
REQ-030 Reset SHALL take priority over start, flush and the write enables, and SHALL abort an operation mid-flight with no done.

Verification
REQ-031 The bench SHALL drive MULT with a=0xFFFFFFFD, b=5 and MUL_LAT=4 -> busy high 4 cycles, then done, hi=0xFFFFFFFF, lo=0xFFFFFFF1.
REQ-032 The bench SHALL drive MULTU with a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
REQ-033 The bench SHALL drive DIV with a=0xFFFFFFF9 (-7), b=2 -> busy 33 cycles, lo=0xFFFFFFFD, hi=0xFFFFFFFF; then DIVU a=0x1234, b=0 -> hi=0x1234, lo=0xFFFFFFFF.
REQ-034 The bench SHALL start DIV, assert flush in busy cycle 10, then try MTHI with wdata=0xA5A5A5A5 while busy and start again during busy -> busy drops next cycle, no done, hi/lo hold prior values, the MTHI has no effect, and the in-busy start is ignored.
REQ-035 The bench SHALL issue a MULTU start in the done cycle of a prior multiply -> it is accepted, busy rises the next cycle, and done pulses exactly once per operation.
REQ-036 The bench SHALL assert reset at divide cycle 20 -> the next cycle has hi=lo=0, busy=0, done=0, and done never pulses for the aborted divide.
